// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide engine, one bit per cycle, stalling the core until done.
// Optional feature macro SIGNED_MULDIV_EN adds MULH/MULHSU/DIV/REM; without it those encodings complete as illegal.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             stall,
  output logic             illegal
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         f3_q, f3_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               illegal_q, illegal_d;

  // Per-iteration datapath
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step, prod_fix;
  logic [WIDTH-1:0]   mul_res;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [WIDTH-1:0]   quot_step, rem_step, div_res;

  // Operand decode at acceptance
  logic               legal, is_div, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;

  always_comb begin
    // Shift-add: multiplier sits in the low half of prod and drains out as the product fills in.
    addend    = prod_q[0] ? opb_q : '0;
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    prod_fix  = neg_res_q ? -prod_step : prod_step;
    mul_res   = (f3_q == 3'b000) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];

    // Restoring divide: rem < divisor always holds, so the shifted value fits in WIDTH+1 bits.
    div_shift = {rem_q, quot_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    quot_step = {quot_q[WIDTH-2:0], ~div_trial[WIDTH]};
    rem_step  = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_res   = f3_q[1] ? (neg_rem_q ? -rem_step : rem_step)
                        : (neg_res_q ? -quot_step : quot_step);
  end

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
    state_d   = state_q;
    f3_d      = f3_q;
    count_d   = count_q;
    prod_d    = prod_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    legal     = 1'b0;
    is_div    = 1'b0;
    sa        = 1'b0;
    sb        = 1'b0;
    mag_a     = a;
    mag_b     = b;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (funct3)
            3'b000, 3'b011: legal = 1'b1;
            3'b101, 3'b111: begin legal = 1'b1; is_div = 1'b1; end
`ifdef SIGNED_MULDIV_EN
            3'b001: begin legal = 1'b1; sa = a[WIDTH-1]; sb = b[WIDTH-1]; end
            3'b010: begin legal = 1'b1; sa = a[WIDTH-1]; end
            3'b100, 3'b110: begin
              legal = 1'b1; is_div = 1'b1; sa = a[WIDTH-1]; sb = b[WIDTH-1];
            end
`endif
            default: legal = 1'b0;
          endcase

          mag_a     = sa ? -a : a;
          mag_b     = sb ? -b : b;
          f3_d      = funct3;
          count_d   = '0;
          prod_d    = {{WIDTH{1'b0}}, mag_a};
          quot_d    = mag_a;
          rem_d     = '0;
          opb_d     = mag_b;
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          illegal_d = 1'b0;

          if (!legal) begin
            state_d   = S_DONE;
            illegal_d = 1'b1;
            result_d  = '0;
          end else if (is_div && (b == '0)) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? a : '1;
          end else if (is_div && sb && (a == INT_MIN) && (b == '1)) begin
            state_d  = S_DONE;
            result_d = funct3[1] ? '0 : a;
          end else begin
            state_d = is_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        prod_d  = prod_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end
      end
      S_DIV: begin
        rem_d   = rem_step;
        quot_d  = quot_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d  = S_DONE;
          result_d = div_res;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      f3_q      <= '0;
      count_q   <= '0;
      prod_q    <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      count_q   <= count_d;
      prod_q    <= prod_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q == S_MUL) || (state_q == S_DIV);
  assign stall   = start & ~done;
  assign illegal = done & illegal_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected results, a negedge monitor pops on done.
// Signed-op expectations follow SIGNED_MULDIV_EN the same way the RTL build does.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         done, busy, stall, illegal;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         ill;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb_q[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .stall(stall), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(result), 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, 64'(result), 64'(e.res));
        check({e.name, "_illegal"}, 64'(illegal), 64'(e.ill));
        check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Issue one op; b2b means start is already high from the previous op's done cycle.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] res, input logic ill,
                       input int lat, input bit b2b, input bit keep);
    int  c;
    int  n_stall;
    bit  seen;
    if (!b2b) @(negedge clk);
    c = cyc;
    start  = 1'b1;
    funct3 = f3;
    a      = av;
    b      = bv;
    sb_q.push_back('{res, ill, c + (b2b ? 2 : 1) + lat, name});
    n_stall = 0;
    #1;
    if (stall) n_stall++;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (stall) n_stall++;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_stall_cycles"}, 64'(n_stall), 64'(lat + 1));
    check({name, "_stall_at_done"}, 64'(stall), 64'd0);
    if (!keep) start = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_result",  64'(result),  64'd0);
    check("reset_done",    64'(done),    64'd0);
    check("reset_busy",    64'(busy),    64'd0);
    check("reset_illegal", 64'(illegal), 64'd0);
    check("reset_stall",   64'(stall),   64'd0);

    // Unsigned multiply
    do_op("mul_7x6",      3'b000, 32'd7,          32'd6,          32'd42,         1'b0, W, 1'b0, 1'b0);
    do_op("mulhu_max",    3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, W, 1'b0, 1'b0);
    do_op("mul_max",      3'b000, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, W, 1'b0, 1'b0);
    do_op("mulhu_carry",  3'b011, 32'h1234_5678,  32'h0000_0010,  32'h0000_0001,  1'b0, W, 1'b0, 1'b0);
    do_op("mul_carry",    3'b000, 32'h1234_5678,  32'h0000_0010,  32'h2345_6780,  1'b0, W, 1'b0, 1'b0);

    // Unsigned divide, including divide by zero
    do_op("divu_100_7",   3'b101, 32'd100,        32'd7,          32'd14,         1'b0, W, 1'b0, 1'b0);
    do_op("remu_100_7",   3'b111, 32'd100,        32'd7,          32'd2,          1'b0, W, 1'b0, 1'b0);
    do_op("divu_max_16",  3'b101, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  1'b0, W, 1'b0, 1'b0);
    do_op("remu_max_16",  3'b111, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F,  1'b0, W, 1'b0, 1'b0);
    do_op("divu_by0",     3'b101, 32'd100,        32'd0,          32'hFFFF_FFFF,  1'b0, 0, 1'b0, 1'b0);
    do_op("remu_5_by0",   3'b111, 32'd5,          32'd0,          32'd5,          1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of a divide: no done pulse, busy drops
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    a      = 32'd100;
    b      = 32'd7;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy_after",   64'(busy),   64'd0);
    check("abort_done_after",   64'(done),   64'd0);
    check("abort_result_after", 64'(result), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_busy_idle", 64'(busy), 64'd0);
    do_op("divu_9_3",     3'b101, 32'd9,          32'd3,          32'd3,          1'b0, W, 1'b0, 1'b0);

    // start held high across two back-to-back multiplies
    do_op("b2b_mul_3x3",  3'b000, 32'd3,          32'd3,          32'd9,          1'b0, W, 1'b0, 1'b1);
    do_op("b2b_mul_4x4",  3'b000, 32'd4,          32'd4,          32'd16,         1'b0, W, 1'b1, 1'b0);

`ifdef SIGNED_MULDIV_EN
    do_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, W, 1'b0, 1'b0);
    do_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, W, 1'b0, 1'b0);
    do_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 0, 1'b0, 1'b0);
    do_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 0, 1'b0, 1'b0);
    do_op("div_by0",      3'b100, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1'b0, 0, 1'b0, 1'b0);
    do_op("rem_by0",      3'b110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1'b0, 0, 1'b0, 1'b0);
    do_op("mulh_m2x3",    3'b001, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, W, 1'b0, 1'b0);
    do_op("mulh_min2",    3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0, W, 1'b0, 1'b0);
    do_op("mulhsu_m1",    3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, W, 1'b0, 1'b0);
`else
    do_op("div_illegal",  3'b100, 32'hFFFF_FFF9,  32'd2,          32'd0,          1'b1, 0, 1'b0, 1'b0);
    do_op("rem_illegal",  3'b110, 32'hFFFF_FFF9,  32'd2,          32'd0,          1'b1, 0, 1'b0, 1'b0);
    do_op("mulh_illegal", 3'b001, 32'hFFFF_FFFE,  32'd3,          32'd0,          1'b1, 0, 1'b0, 1'b0);
    do_op("mulhsu_illeg", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1, 0, 1'b0, 1'b0);
`endif

    // A legal op right after must clear the illegal flag
    do_op("mul_after",    3'b000, 32'd5,          32'd5,          32'd25,         1'b0, W, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
